// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load byte/half extraction, sign/zero extension and
// misaligned-load detection. Optional retire counter enabled by `MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [31:0]       alu,
  input  logic [31:0]       dmem_odata,
  input  logic [2:0]        load_type,
  input  logic              rf_wena,
  input  logic [REG_AW-1:0] rf_waddr,
  output logic              wb_valid,
  output logic              wb_rf_wena,
  output logic [REG_AW-1:0] wb_waddr,
  output logic [31:0]       wb_wdata,
  output logic              wb_adel,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam logic [2:0] LT_LW  = 3'd1;
  localparam logic [2:0] LT_LH  = 3'd2;
  localparam logic [2:0] LT_LHU = 3'd3;
  localparam logic [2:0] LT_LB  = 3'd4;
  localparam logic [2:0] LT_LBU = 3'd5;

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] fmt_data;
  logic        misaligned;
  logic [31:0] wdata_next;
  logic        wena_next;
  logic        adel_next;

  // Little-endian lane select: alu[1:0] picks the byte, alu[1] picks the half.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    load_byte  = dmem_odata[7:0];
    load_half  = dmem_odata[15:0];
    fmt_data   = alu;
    misaligned = 1'b0;

    case (alu[1:0])
      2'd0:    load_byte = dmem_odata[7:0];
      2'd1:    load_byte = dmem_odata[15:8];
      2'd2:    load_byte = dmem_odata[23:16];
      default: load_byte = dmem_odata[31:24];
    endcase
    load_half = alu[1] ? dmem_odata[31:16] : dmem_odata[15:0];

    case (load_type)
      LT_LW: begin
        fmt_data   = dmem_odata;
        misaligned = (alu[1:0] != 2'd0);
      end
      LT_LH: begin
        fmt_data   = {{16{load_half[15]}}, load_half};
        misaligned = alu[0];
      end
      LT_LHU: begin
        fmt_data   = {16'd0, load_half};
        misaligned = alu[0];
      end
      LT_LB:   fmt_data = {{24{load_byte[7]}}, load_byte};
      LT_LBU:  fmt_data = {24'd0, load_byte};
      default: fmt_data = alu;
    endcase

    wdata_next = misaligned ? 32'd0 : fmt_data;
    wena_next  = in_valid & rf_wena & (rf_waddr != '0) & ~misaligned;
    adel_next  = in_valid & misaligned;
  end

  // Priority: rst > flush > stall > load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_rf_wena <= 1'b0;
      wb_waddr   <= '0;
      wb_wdata   <= 32'd0;
      wb_adel    <= 1'b0;
    end else if (flush) begin
      wb_valid   <= 1'b0;
      wb_rf_wena <= 1'b0;
      wb_waddr   <= '0;
      wb_wdata   <= 32'd0;
      wb_adel    <= 1'b0;
    end else if (!stall) begin
      wb_valid   <= in_valid;
      wb_rf_wena <= wena_next;
      wb_waddr   <= rf_waddr;
      wb_wdata   <= wdata_next;
      wb_adel    <= adel_next;
    end
  end

`ifdef MEM_WB_RETIRE_CNT_EN
  // Counts every valid instruction entering WB, misaligned ones included; wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (!flush && !stall && in_valid) begin
      retire_cnt <= retire_cnt + 1'b1;
    end
  end
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage against a behavioural model.
// With `MEM_WB_RETIRE_CNT_EN defined the DUT is built with CNT_W=4 to exercise wrap.
module tb_mem_wb_stage;

`ifdef MEM_WB_RETIRE_CNT_EN
  localparam int TB_CNT_W = 4;
  localparam bit CNT_ON   = 1'b1;
`else
  localparam int TB_CNT_W = 32;
  localparam bit CNT_ON   = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst, stall, flush, in_valid, rf_wena;
  logic [31:0]         alu, dmem_odata;
  logic [2:0]          load_type;
  logic [4:0]          rf_waddr;
  logic                wb_valid, wb_rf_wena, wb_adel;
  logic [4:0]          wb_waddr;
  logic [31:0]         wb_wdata;
  logic [TB_CNT_W-1:0] retire_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state
  logic                exp_valid, exp_wena, exp_adel;
  logic [4:0]          exp_waddr;
  logic [31:0]         exp_wdata;
  logic [TB_CNT_W-1:0] exp_cnt;

  always #5 clk = ~clk;

  mem_wb_stage #(.REG_AW(5), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu(alu), .dmem_odata(dmem_odata), .load_type(load_type), .rf_wena(rf_wena),
    .rf_waddr(rf_waddr), .wb_valid(wb_valid), .wb_rf_wena(wb_rf_wena),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_adel(wb_adel), .retire_cnt(retire_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_misaligned(input int lt, input logic [31:0] a);
    int unsigned off = a % 4;
    if (lt == 1) return off != 0;
    if (lt == 2 || lt == 3) return (off % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_value(input int lt, input logic [31:0] a,
                                             input logic [31:0] d);
    int unsigned bval = (d >> (8 * (a % 4))) % 256;
    int unsigned hval = (d >> (16 * ((a / 2) % 2))) % 65536;
    case (lt)
      1: return d;
      2: return (hval >= 32768) ? 32'(hval) - 32'd65536 : 32'(hval);
      3: return 32'(hval);
      4: return (bval >= 128) ? 32'(bval) - 32'd256 : 32'(bval);
      5: return 32'(bval);
      default: return a;
    endcase
  endfunction

  task automatic model_edge();
    bit mis;
    if (rst) begin
      {exp_valid, exp_wena, exp_adel} = 3'b000;
      exp_waddr = 0; exp_wdata = 0; exp_cnt = 0;
    end else if (flush) begin
      {exp_valid, exp_wena, exp_adel} = 3'b000;
      exp_waddr = 0; exp_wdata = 0;
    end else if (!stall) begin
      mis       = is_misaligned(int'(load_type), alu);
      exp_valid = in_valid;
      exp_waddr = rf_waddr;
      exp_wdata = mis ? 32'd0 : load_value(int'(load_type), alu, dmem_odata);
      exp_adel  = in_valid && mis;
      exp_wena  = in_valid && rf_wena && (rf_waddr != 0) && !mis;
      if (CNT_ON && in_valid) exp_cnt = exp_cnt + 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 64'(wb_valid), 64'(exp_valid));
    check({tag, ".wena"},  64'(wb_rf_wena), 64'(exp_wena));
    check({tag, ".waddr"}, 64'(wb_waddr), 64'(exp_waddr));
    check({tag, ".wdata"}, 64'(wb_wdata), 64'(exp_wdata));
    check({tag, ".adel"},  64'(wb_adel), 64'(exp_adel));
    check({tag, ".cnt"},   64'(retire_cnt), 64'(exp_cnt));
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic v,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] lt,
                       input logic we, input logic [4:0] wa, input string tag);
    rst = r; stall = s; flush = f; in_valid = v;
    alu = a; dmem_odata = d; load_type = lt; rf_wena = we; rf_waddr = wa;
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  initial begin
    exp_valid = 0; exp_wena = 0; exp_adel = 0; exp_waddr = 0; exp_wdata = 0; exp_cnt = 0;

    // Reset with a valid instruction presented
    drive(1, 0, 0, 1, 32'h1234, 32'hDEAD_BEEF, 3'd1, 1, 5'd3, "rst0");
    drive(1, 1, 1, 1, 32'h1234, 32'hDEAD_BEEF, 3'd1, 1, 5'd3, "rst1");
    check("rst_valid", 64'(wb_valid), 64'd0);
    check("rst_wdata", 64'(wb_wdata), 64'd0);

    // Byte loads
    drive(0, 0, 0, 1, 32'h103, 32'h80FF_7F01, 3'd4, 1, 5'd5, "lb");
    check("lb_data", 64'(wb_wdata), 64'hFFFF_FF80);
    drive(0, 0, 0, 1, 32'h103, 32'h80FF_7F01, 3'd5, 1, 5'd5, "lbu");
    check("lbu_data", 64'(wb_wdata), 64'h0000_0080);

    // Half loads, aligned then misaligned
    drive(0, 0, 0, 1, 32'h102, 32'h8001_1234, 3'd2, 1, 5'd6, "lh");
    check("lh_data", 64'(wb_wdata), 64'hFFFF_8001);
    drive(0, 0, 0, 1, 32'h101, 32'h8001_1234, 3'd2, 1, 5'd6, "lh_mis");
    check("lh_mis_adel", 64'(wb_adel), 64'd1);
    check("lh_mis_wena", 64'(wb_rf_wena), 64'd0);

    // ALU op to $0 and to $8
    drive(0, 0, 0, 1, 32'h1234, 32'h0, 3'd0, 1, 5'd0, "alu_r0");
    check("alu_r0_wena", 64'(wb_rf_wena), 64'd0);
    check("alu_r0_valid", 64'(wb_valid), 64'd1);
    drive(0, 0, 0, 1, 32'h1234, 32'h0, 3'd0, 1, 5'd8, "alu_r8");
    check("alu_r8_data", 64'(wb_wdata), 64'h1234);
    check("alu_r8_wena", 64'(wb_rf_wena), 64'd1);

    // LW then 3-cycle stall with changing inputs, then stall+flush
    drive(0, 0, 0, 1, 32'h200, 32'hCAFE_F00D, 3'd1, 1, 5'd9, "lw");
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, $urandom, $urandom, 3'($urandom_range(0, 7)), 1, 5'd17, "stall");
      check("stall_data", 64'(wb_wdata), 64'hCAFE_F00D);
      check("stall_addr", 64'(wb_waddr), 64'd9);
    end
    drive(0, 1, 1, 1, 32'h300, 32'h1, 3'd1, 1, 5'd4, "stflush");
    check("stflush_valid", 64'(wb_valid), 64'd0);

    // 17 valid loads interleaved with 2 stalls and 1 flush after reset
    drive(1, 0, 0, 0, 32'h0, 32'h0, 3'd0, 0, 5'd0, "cnt_rst");
    for (int i = 0; i < 20; i++) begin
      drive(0, (i == 4 || i == 11), (i == 15), 1, 32'(i * 4), $urandom, 3'd1, 1, 5'd1,
            "cnt");
    end
    check("cnt_wrap", 64'(retire_cnt), CNT_ON ? 64'd1 : 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa;
      wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0,
            $urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom), wa, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
